// File: rtl/fold_sig_collect.sv
// fold_sig_collect: per-stream 8-bit signatures of folded byte pairs over a frame, held on a valid/ready output.
// Build option: define FOLD_SIG_ROTATE_EN for a rotate-XOR (order-sensitive) signature instead of plain XOR parity.
module fold_sig_collect #(
    parameter int FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic [7:0] aa,
    input  logic [7:0] bb,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] sig_a,
    output logic [7:0] sig_b,
    output logic       sig_eq,
    output logic [8:0] out_len
);

    localparam logic [8:0] LEN_MAX = 9'(FRAME_LEN);

    typedef enum logic {ACC, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] acc_a, acc_b;
    logic [7:0] acc_a_nxt, acc_b_nxt;
    logic [8:0] cnt, cnt_inc;
    logic       accept, frame_end;

    function automatic logic [7:0] mix(input logic [7:0] s);
`ifdef FOLD_SIG_ROTATE_EN
        return {s[6:0], s[7]};
`else
        return s;
`endif
    endfunction

    always_comb begin
        accept    = in_valid && in_ready;
        cnt_inc   = cnt + 9'd1;
        acc_a_nxt = mix(acc_a) ^ aa;
        acc_b_nxt = mix(acc_b) ^ bb;
        // A word with in_last on the FRAME_LEN-th slot is still one frame end.
        frame_end = accept && (in_last || (cnt_inc == LEN_MAX));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (frame_end) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // Handshake flags come straight from the state, so nothing on the input side reaches them combinationally.
    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == HOLD);
    end

    // NOTE: result registers are reset too, so outputs read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_a   <= 8'h00;
            acc_b   <= 8'h00;
            cnt     <= 9'd0;
            sig_a   <= 8'h00;
            sig_b   <= 8'h00;
            sig_eq  <= 1'b0;
            out_len <= 9'd0;
        end else if (frame_end) begin
            sig_a   <= acc_a_nxt;
            sig_b   <= acc_b_nxt;
            sig_eq  <= (acc_a_nxt == acc_b_nxt);
            out_len <= cnt_inc;
            acc_a   <= 8'h00;
            acc_b   <= 8'h00;
            cnt     <= 9'd0;
        end else if (accept) begin
            acc_a   <= acc_a_nxt;
            acc_b   <= acc_b_nxt;
            cnt     <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_fold_sig_collect.sv
// Scoreboard bench for fold_sig_collect: drivers queue expected frame results, monitors compare on out_valid.
// Two instances: FRAME_LEN=4 for handshake/corner work and FRAME_LEN=256 for the full-width length case.
module tb_fold_sig_collect;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0] sa;
        logic [7:0] sb;
        logic       eq;
        logic [8:0] len;
    } exp_t;

    int checks = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, in_last, out_valid, out_ready, sig_eq;
    logic [7:0] aa, bb, sig_a, sig_b;
    logic [8:0] out_len;

    logic       rst_n_b, in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, sig_eq_b;
    logic [7:0] aa_b, bb_b, sig_a_b, sig_b_b;
    logic [8:0] out_len_b;

    exp_t    q_a[$];
    exp_t    q_b[$];
    byte_q_t fa, fb;
    int      or_mode = 0;
    bit      done_b = 1'b0;

    always #5 clk = ~clk;

    fold_sig_collect #(.FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .aa(aa), .bb(bb), .out_valid(out_valid), .out_ready(out_ready),
        .sig_a(sig_a), .sig_b(sig_b), .sig_eq(sig_eq), .out_len(out_len)
    );

    fold_sig_collect #(.FRAME_LEN(256)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_last(in_last_b),
        .aa(aa_b), .bb(bb_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .sig_a(sig_a_b), .sig_b(sig_b_b), .sig_eq(sig_eq_b), .out_len(out_len_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the signature is the XOR of every word, each rotated left by the number of words after it.
    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] model_sig(input byte_q_t w);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < w.size(); i++) begin
`ifdef FOLD_SIG_ROTATE_EN
            s ^= rotl(w[i], (w.size() - 1 - i) % 8);
`else
            s ^= w[i];
`endif
        end
        return s;
    endfunction

    function automatic exp_t make_exp(input byte_q_t wa, input byte_q_t wb);
        exp_t e;
        e.sa  = model_sig(wa);
        e.sb  = model_sig(wb);
        e.eq  = (e.sa == e.sb);
        e.len = 9'(wa.size());
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] sa, input logic [7:0] sb,
                       input logic eq, input logic [8:0] len);
        check({tag, "_sig_a"}, sa, e.sa);
        check({tag, "_sig_b"}, sb, e.sb);
        check({tag, "_sig_eq"}, eq, e.eq);
        check({tag, "_out_len"}, len, e.len);
    endtask

    // out_ready policy: 0 always ready, 1 random, 2 stalled
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor A: compares every cycle out_valid is high, which also checks stability under backpressure.
    initial begin
        bit just_popped = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                just_popped = 1'b0;
            end else begin
                if (just_popped) begin
                    check("hold_one_cycle_out_valid", out_valid, 0);
                    check("hold_one_cycle_in_ready", in_ready, 1);
                    just_popped = 1'b0;
                end
                if (out_valid) begin
                    if (q_a.size() == 0) begin
                        check("unexpected_out_valid", out_valid, 0);
                    end else begin
                        cmp("a", q_a[0], sig_a, sig_b, sig_eq, out_len);
                        if (out_ready) begin
                            void'(q_a.pop_front());
                            just_popped = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n_b && out_valid_b) begin
                if (q_b.size() == 0) begin
                    check("unexpected_out_valid_b", out_valid_b, 0);
                end else begin
                    cmp("b", q_b[0], sig_a_b, sig_b_b, sig_eq_b, out_len_b);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    task automatic send_frame(input bit last_on_final, input bit bubbles);
        int n;
        n = fa.size();
        q_a.push_back(make_exp(fa, fb));
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'($urandom_range(0, 1));
                aa = 8'($urandom);
                bb = 8'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            aa = fa[i];
            bb = fb[i];
            in_last = (i == n - 1) ? last_on_final : 1'b0;
            @(negedge clk);
            check("in_ready_acc", in_ready, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("out_valid_latency", out_valid, 1);
        check("in_ready_hold", in_ready, 0);
    endtask

    // Drives 0x33 junk while the block is not ready; junk is withdrawn before any edge where in_ready is 1.
    task automatic wait_ready(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            aa = 8'h33;
            bb = 8'h33;
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        check("wait_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_frame(input int n, input bit same);
        fa = {};
        fb = {};
        for (int i = 0; i < n; i++) begin
            fa.push_back(8'($urandom));
            fb.push_back(same ? fa[i] : 8'($urandom));
        end
    endtask

    // FRAME_LEN=256 instance: full-length frames with no in_last.
    initial begin
        byte_q_t wa, wb;
        int guard;
        rst_n_b = 1'b0;
        in_valid_b = 1'b0;
        in_last_b = 1'b0;
        aa_b = 8'h00;
        bb_b = 8'h00;
        out_ready_b = 1'b1;
        #12 rst_n_b = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wa = {};
            wb = {};
            for (int i = 0; i < 256; i++) begin
                wa.push_back((f == 0) ? 8'h01 : 8'($urandom));
                wb.push_back((f == 0) ? 8'h01 : 8'($urandom));
            end
            q_b.push_back(make_exp(wa, wb));
            for (int i = 0; i < 256; i++) begin
                @(posedge clk);
                #1;
                in_valid_b = 1'b1;
                aa_b = wa[i];
                bb_b = wb[i];
            end
            @(posedge clk);
            #1;
            in_valid_b = 1'b0;
            @(negedge clk);
            check("b_out_valid_latency", out_valid_b, 1);
            guard = 0;
            while (!in_ready_b && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            check("b_in_ready_return", in_ready_b, 1);
        end
        done_b = 1'b1;
    end

    initial begin
        int w;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        aa = 8'h00;
        bb = 8'h00;
        #7;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sig_a", sig_a, 0);
        check("rst_sig_b", sig_b, 0);
        check("rst_sig_eq", sig_eq, 0);
        check("rst_out_len", out_len, 0);
        #5 rst_n = 1'b1;

        // Length-terminated frame of single bits, always ready.
        fa = {8'h01, 8'h02, 8'h04, 8'h08};
        fb = fa;
        send_frame(1'b0, 1'b0);
        wait_ready(20);

        fa = {8'hFF, 8'h80};
        fb = {8'hFF, 8'h00};
        send_frame(1'b1, 1'b0);
        wait_ready(20);

        fa = {8'h5A};
        fb = {8'h5A};
        send_frame(1'b1, 1'b0);
        wait_ready(20);

        // in_last coinciding with the FRAME_LEN-th word.
        set_frame(4, 1'b0);
        send_frame(1'b1, 1'b0);
        wait_ready(20);

        // Backpressure with 0x33 junk offered while held.
        or_mode = 2;
        set_frame(3, 1'b0);
        send_frame(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            aa = 8'h33;
            bb = 8'h33;
            in_last = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        or_mode = 0;
        wait_ready(20);
        set_frame(2, 1'b0);
        send_frame(1'b1, 1'b0);
        wait_ready(20);

        // Asynchronous reset pulse between edges after two accepted words.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            aa = 8'($urandom);
            bb = 8'($urandom);
            in_last = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_sig_a", sig_a, 0);
        check("mid_rst_sig_b", sig_b, 0);
        check("mid_rst_sig_eq", sig_eq, 0);
        check("mid_rst_out_len", out_len, 0);
        #1 rst_n = 1'b1;
        fa = {8'h10, 8'h10, 8'h10, 8'h10};
        fb = fa;
        send_frame(1'b0, 1'b0);
        wait_ready(20);

        // Randomized frames with bubbles and random out_ready.
        for (int f = 0; f < 40; f++) begin
            int n;
            bit last_f;
            n = $urandom_range(1, 4);
            set_frame(n, ($urandom_range(0, 3) == 0));
            last_f = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            or_mode = $urandom_range(0, 1);
            send_frame(last_f, 1'b1);
            wait_ready(60);
        end
        or_mode = 0;

        w = 0;
        while (!done_b && w < 5000) begin
            @(posedge clk);
            w++;
        end
        check("b_done", done_b, 1);
        repeat (4) @(posedge clk);
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fold_sig_collect.md
# fold_sig_collect

Downstream consumer of the 16-to-8 XOR fold stage. Accepts one folded byte pair (`aa`, `bb`) per cycle under a valid/ready handshake and accumulates an 8-bit signature per stream over a frame. A frame ends on `in_last` or after `FRAME_LEN` words, whichever comes first. It then presents both signatures, an equality flag and the frame length on a held output handshake for the checker/logging stage.

## Interface
- `FRAME_LEN`, default 16: maximum words per frame. Legal range 1..256.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `aa`/`bb`/`in_last` are valid this cycle.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_last`  in  1  the accepted word is the final word of the frame.
- `aa`  in  8  folded byte, stream A.
- `bb`  in  8  folded byte, stream B.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer takes the result.
- `sig_a`  out  8  stream A signature.
- `sig_b`  out  8  stream B signature.
- `sig_eq`  out  1  `sig_a == sig_b`.
- `out_len`  out  9  words in the completed frame, 1..256.

## Operation
- Two states:
  - ACC (reset state): `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- `in_ready` is decoded directly from the state, so it reads 1 while in reset.
- A word is accepted when `in_valid && in_ready`.
- Internal registers: `acc_a`, `acc_b` (8 bits each) and `cnt` (9 bits).
- Update on accept:
  - `acc_x <= F(acc_x) ^ x`, where F is the mix function (see Configuration).
  - `cnt <= cnt + 1`.
  - On the first word of a frame (`cnt==0`), the accumulator is zero, so `acc_x` becomes `x`.
- Frame end is an accepted word with `in_last==1` or `cnt+1 == FRAME_LEN`. On that edge:
  - `sig_a`/`sig_b` load the updated accumulator values.
  - `sig_eq` loads their comparison.
  - `out_len` loads `cnt+1`.
  - `acc_a`, `acc_b` and `cnt` clear.
  - State goes to HOLD.
- HOLD:
  - Inputs are ignored.
  - `sig_a`, `sig_b`, `sig_eq` and `out_len` stay stable until `out_valid && out_ready`.
  - On that handshake the state returns to ACC on the next edge.
  - The result registers keep their values; only `out_valid` drops.
- `in_last` on a word with `cnt+1 == FRAME_LEN` is a single frame end, never two.
- `in_last` on the first word gives `out_len=1`.
- `in_last` is ignored when `in_valid=0`.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=1`.
  - `sig_a=0x00`, `sig_b=0x00`, `sig_eq=0`, `out_len=0`.
  - `acc_a`, `acc_b`, `cnt` = 0.
- Latency: `out_valid` rises on the edge that accepts the final word, so it is visible in the cycle after the final `in_valid` cycle.
- Throughput:
  - 1 word/cycle within a frame.
  - At least 1 bubble cycle per frame; HOLD lasts at least one cycle even with `out_ready` held at 1.
- Input to output is registered only; there is no combinational path from `in_valid`/`aa`/`bb` to any output.
- Reset asserted mid-frame or during HOLD:
  - The partial frame or pending result is discarded immediately, without waiting for an edge.
  - The first accepted word after `rst_n` rises starts a new frame.
- Counter `cnt` never exceeds `FRAME_LEN-1` between frames. `out_len` of 256 requires the 9-bit width.

## Configuration
- `FOLD_SIG_ROTATE_EN` defined: `F(s) = {s[6:0], s[7]}`, a rotate left by 1 (MISR-style, order-sensitive signature).
- `FOLD_SIG_ROTATE_EN` undefined: `F(s) = s`, a plain XOR parity of all words (order-insensitive).
- Handshake, timing and `out_len` are identical in both builds.

## Test plan
- `FRAME_LEN=4`, `aa=bb`=0x01,0x02,0x04,0x08 back-to-back, `out_ready=1`:
  - With rotate: `sig_a=sig_b=0x00`.
  - Without rotate: 0x0F.
  - Both builds: `sig_eq=1`, `out_len=4`, `out_valid` high one cycle after the 4th word, `in_ready=0` for exactly 1 cycle.
- `in_last` on 2nd word, `aa`=0xFF,0x80 and `bb`=0xFF,0x00:
  - With rotate: `sig_a=0x7F`, `sig_b=0xFF`.
  - Without rotate: `sig_a=0x7F`, `sig_b=0xFF`.
  - `sig_eq=0`, `out_len=2`.
- `in_last` on the first word, `aa=0x5A`, `bb=0x5A`: `sig_a=sig_b=0x5A`, `sig_eq=1`, `out_len=1`.
- Backpressure: complete a frame, hold `out_ready=0` for 5 cycles while driving `in_valid=1` with 0x33 data:
  - Outputs remain stable.
  - `in_ready=0` throughout.
  - No 0x33 word is absorbed into the next frame.
- Reset mid-frame: accept 2 words, pulse `rst_n` low between edges, then send 4 words of `aa=bb=0x10`:
  - Outputs read reset values during reset.
  - With rotate: result 0xF0. Without rotate: 0x00.
  - `out_len=4`.
- `FRAME_LEN=256`, 256 words of 0x01 with no `in_last`:
  - With rotate: `sig_a=0x00`. Without rotate: 0x00.
  - `out_len=256`.
